// File: rtl/score_lives.sv
// Game-level score and lives keeper: BCD kill score, breach-driven life loss,
// the idle/play/over FSM that drives gameover, and a session high score.
module score_lives #(
   parameter int unsigned N_ENEMY      = 8,
   parameter int unsigned BREACH_Y     = 440,
   parameter int unsigned START_LIVES  = 3,
   parameter int unsigned SCORE_DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      killed,
   input  logic [N_ENEMY-1:0]        enemy_alive,
   input  logic [8:0]                enemy_y [N_ENEMY],
   output logic                      gameover,
   output logic                      playing,
   output logic [2:0]                lives,
   output logic                      life_lost,
   output logic [4*SCORE_DIGITS-1:0] score,
   output logic [4*SCORE_DIGITS-1:0] high_score
);
   localparam int unsigned SW        = 4 * SCORE_DIGITS;
   localparam int unsigned CntW      = $clog2(N_ENEMY + 1) + 3;
   localparam logic [8:0]  BreachRow = 9'(BREACH_Y);
   localparam logic [2:0]  LivesInit = 3'(START_LIVES);

   typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;

   state_e             state_q, state_d;
   logic [2:0]         lives_q, lives_d;
   logic               life_lost_q, life_lost_d;
   logic [SW-1:0]      score_q, score_d, high_q, high_d, score_inc;
   logic [N_ENEMY-1:0] breach_prev_q, breach_prev_d, breach_now, breach_new;
   logic [CntW-1:0]    n_new;
   logic               score_full, carry;

   // Only rising breach flags cost a life; a slot must leave the zone to re-arm.
   always_comb begin
      breach_now = '0;
      n_new      = '0;
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
         breach_now[i] = enemy_alive[i] && (enemy_y[i] >= BreachRow);
      end
      breach_new = breach_now & ~breach_prev_q;
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
         n_new = n_new + CntW'(breach_new[i]);
      end
   end

   always_comb begin
      score_full = 1'b1;
      score_inc  = score_q;
      carry      = 1'b1;
      for (int unsigned d = 0; d < SCORE_DIGITS; d++) begin
         if (score_q[4*d +: 4] != 4'd9) score_full = 1'b0;
         if (carry) begin
            if (score_q[4*d +: 4] == 4'd9) begin
               score_inc[4*d +: 4] = 4'd0;
            end else begin
               score_inc[4*d +: 4] = score_q[4*d +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      lives_d       = lives_q;
      life_lost_d   = 1'b0;
      score_d       = score_q;
      high_d        = high_q;
      breach_prev_d = breach_prev_q;
      case (state_q)
         StIdle, StOver: begin
            if (start) begin
               state_d       = StPlay;
               lives_d       = LivesInit;
               score_d       = '0;
               breach_prev_d = '0;
            end
         end
         StPlay: begin
            breach_prev_d = breach_now;
            if (killed && !score_full) score_d = score_inc;
            if (n_new >= CntW'(lives_q)) lives_d = '0;
            else                         lives_d = lives_q - 3'(n_new);
            life_lost_d = (n_new != '0);
            // The final-cycle kill is already in score_d, so it counts for the best score.
            if (lives_d == '0) begin
               state_d = StOver;
               if (score_d > high_q) high_d = score_d;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         lives_q       <= '0;
         life_lost_q   <= 1'b0;
         score_q       <= '0;
         high_q        <= '0;
         breach_prev_q <= '0;
      end else begin
         state_q       <= state_d;
         lives_q       <= lives_d;
         life_lost_q   <= life_lost_d;
         score_q       <= score_d;
         high_q        <= high_d;
         breach_prev_q <= breach_prev_d;
      end
   end

   assign gameover   = (state_q == StOver);
   assign playing    = (state_q == StPlay);
   assign lives      = lives_q;
   assign life_lost  = life_lost_q;
   assign score      = score_q;
   assign high_score = high_q;

endmodule

// File: tb/tb_score_lives.sv
// Directed bench for score_lives: a vector table for the single-game flow, then
// hand sequences for score saturation, high-score tracking and mid-game reset.
module tb_score_lives;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, start, killed;
   logic [7:0]  enemy_alive;
   logic [8:0]  enemy_y [8];
   logic        gameover, playing, life_lost;
   logic [2:0]  lives;
   logic [15:0] score, high_score;

   int checks = 0;
   int errors = 0;

   score_lives dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .killed      (killed),
      .enemy_alive (enemy_alive),
      .enemy_y     (enemy_y),
      .gameover    (gameover),
      .playing     (playing),
      .lives       (lives),
      .life_lost   (life_lost),
      .score       (score),
      .high_score  (high_score)
   );

   typedef struct {
      logic        st, kl;
      logic [7:0]  alive;
      logic [8:0]  y0, y1, y2, y3, y5;
      logic        pl, ov;
      logic [2:0]  lv;
      logic        ll;
      logic [15:0] sc, hi;
   } vec_t;

   vec_t tbl [16];

   function automatic vec_t mk(input logic st, input logic kl, input logic [7:0] alive,
                               input logic [8:0] y0, input logic [8:0] y1,
                               input logic [8:0] y2, input logic [8:0] y3,
                               input logic [8:0] y5, input logic pl, input logic ov,
                               input logic [2:0] lv, input logic ll,
                               input logic [15:0] sc, input logic [15:0] hi);
      vec_t v;
      v.st = st; v.kl = kl; v.alive = alive;
      v.y0 = y0; v.y1 = y1; v.y2 = y2; v.y3 = y3; v.y5 = y5;
      v.pl = pl; v.ov = ov; v.lv = lv; v.ll = ll; v.sc = sc; v.hi = hi;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_y(input logic [8:0] y0, input logic [8:0] y1, input logic [8:0] y2,
                        input logic [8:0] y3, input logic [8:0] y5);
      for (int i = 0; i < 8; i++) enemy_y[i] = 9'd0;
      enemy_y[0] = y0; enemy_y[1] = y1; enemy_y[2] = y2; enemy_y[3] = y3; enemy_y[5] = y5;
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_all(input string name, input logic pl, input logic ov,
                            input logic [2:0] lv, input logic ll,
                            input logic [15:0] sc, input logic [15:0] hi);
      check({name, ".playing"},    16'(playing),   16'(pl));
      check({name, ".gameover"},   16'(gameover),  16'(ov));
      check({name, ".lives"},      16'(lives),     16'(lv));
      check({name, ".life_lost"},  16'(life_lost), 16'(ll));
      check({name, ".score"},      score,          sc);
      check({name, ".high_score"}, high_score,     hi);
   endtask

   task automatic kill_n(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         killed = 1'b1;
         tick();
         killed = 1'b0;
         for (int g = 1; g < gap; g++) tick();
      end
   endtask

   // Slots 0, 3 and 5 breach together; with three or fewer lives this ends the game.
   task automatic end_game(input string name, input logic kill, input logic [15:0] sc,
                           input logic [15:0] hi);
      enemy_alive = 8'b0010_1001;
      set_y(9'd440, 9'd0, 9'd0, 9'd440, 9'd440);
      killed = kill;
      tick();
      check_all(name, 1'b0, 1'b1, 3'd0, 1'b1, sc, hi);
      enemy_alive = 8'h00;
      killed      = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      tbl[0]  = mk(1, 0, 8'h00, 0,   0,   0,   0,   0,   1, 0, 3, 0, 16'h0000, 16'h0000);
      tbl[1]  = mk(0, 1, 8'h00, 0,   0,   0,   0,   0,   1, 0, 3, 0, 16'h0001, 16'h0000);
      tbl[2]  = mk(0, 0, 8'h00, 0,   0,   0,   0,   0,   1, 0, 3, 0, 16'h0001, 16'h0000);
      tbl[3]  = mk(1, 1, 8'h00, 0,   0,   0,   0,   0,   1, 0, 3, 0, 16'h0002, 16'h0000);
      tbl[4]  = mk(0, 0, 8'h04, 0,   0,   439, 0,   0,   1, 0, 3, 0, 16'h0002, 16'h0000);
      tbl[5]  = mk(0, 0, 8'h04, 0,   0,   440, 0,   0,   1, 0, 2, 1, 16'h0002, 16'h0000);
      tbl[6]  = mk(0, 0, 8'h04, 0,   0,   440, 0,   0,   1, 0, 2, 0, 16'h0002, 16'h0000);
      tbl[7]  = mk(0, 0, 8'h04, 0,   0,   440, 0,   0,   1, 0, 2, 0, 16'h0002, 16'h0000);
      tbl[8]  = mk(0, 0, 8'h04, 0,   0,   100, 0,   0,   1, 0, 2, 0, 16'h0002, 16'h0000);
      tbl[9]  = mk(0, 0, 8'h04, 0,   0,   445, 0,   0,   1, 0, 1, 1, 16'h0002, 16'h0000);
      tbl[10] = mk(0, 1, 8'h00, 0,   0,   445, 0,   0,   1, 0, 1, 0, 16'h0003, 16'h0000);
      tbl[11] = mk(0, 0, 8'h04, 0,   0,   445, 0,   0,   0, 1, 0, 1, 16'h0003, 16'h0003);
      tbl[12] = mk(0, 1, 8'h04, 0,   0,   445, 0,   0,   0, 1, 0, 0, 16'h0003, 16'h0003);
      tbl[13] = mk(1, 0, 8'h00, 0,   0,   0,   0,   0,   1, 0, 3, 0, 16'h0000, 16'h0003);
      tbl[14] = mk(0, 0, 8'h2B, 440, 439, 0,   511, 440, 0, 1, 0, 1, 16'h0000, 16'h0003);
      tbl[15] = mk(0, 0, 8'h00, 0,   0,   0,   0,   0,   0, 1, 0, 0, 16'h0000, 16'h0003);

      // Reset wins over a simultaneous start request.
      reset_n = 1'b0; start = 1'b1; killed = 1'b1; enemy_alive = 8'h00;
      set_y(0, 0, 0, 0, 0);
      tick();
      tick();
      check_all("reset", 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);
      reset_n = 1'b1; start = 1'b0; killed = 1'b0;

      for (int i = 0; i < 16; i++) begin
         start       = tbl[i].st;
         killed      = tbl[i].kl;
         enemy_alive = tbl[i].alive;
         set_y(tbl[i].y0, tbl[i].y1, tbl[i].y2, tbl[i].y3, tbl[i].y5);
         tick();
         check_all($sformatf("vec%0d", i), tbl[i].pl, tbl[i].ov, tbl[i].lv, tbl[i].ll,
                   tbl[i].sc, tbl[i].hi);
      end
      start = 1'b0; killed = 1'b0; enemy_alive = 8'h00;

      // BCD carry and saturation.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      do_start();
      kill_n(10, 2);
      check("score_ten", score, 16'h0010);
      killed = 1'b1;
      repeat (9989) tick();
      check("score_9999", score, 16'h9999);
      tick();
      killed = 1'b0;
      check("score_sat", score, 16'h9999);
      check("sat_lives", 16'(lives), 16'd3);

      // High score across games of the session.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      do_start();
      kill_n(25, 1);
      end_game("game1", 1'b0, 16'h0025, 16'h0025);
      do_start();
      check_all("restart", 1'b1, 1'b0, 3'd3, 1'b0, 16'h0000, 16'h0025);
      kill_n(12, 1);
      end_game("game2", 1'b0, 16'h0012, 16'h0025);
      do_start();
      kill_n(29, 1);
      end_game("game3", 1'b1, 16'h0030, 16'h0030);

      // Reset mid-game discards everything; inputs are ignored until start.
      do_start();
      kill_n(7, 2);
      enemy_alive = 8'h04;
      set_y(0, 0, 9'd440, 0, 0);
      tick();
      check_all("game4", 1'b1, 1'b0, 3'd2, 1'b1, 16'h0007, 16'h0030);
      enemy_alive = 8'h00;
      tick();
      reset_n     = 1'b0;
      killed      = 1'b1;
      enemy_alive = 8'b0010_1001;
      set_y(9'd440, 0, 0, 9'd440, 9'd440);
      tick();
      check_all("midreset", 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);
      reset_n = 1'b1;
      repeat (3) tick();
      check_all("idle_ignore", 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
